// File: rtl/tpram_arbiter_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// Holds the requester-ID type and the read-issue credit limit.
package tpram_arbiter_pkg;

   typedef logic req_id_t;

   localparam int unsigned IssueCredits = 2;

   // Reads in flight or buffered, counting an output-register drain this cycle as already freed.
   function automatic logic [1:0] occupancy(logic inflight, logic rsp_valid, logic skid_valid,
                                            logic drain);
      return 2'(inflight) + 2'(rsp_valid) + 2'(skid_valid) - 2'(drain);
   endfunction

endpackage

// File: rtl/tpram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer flips only when both requesters compete.
module rr_arb2 (
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic [1:0] valid_i,
   output logic [1:0] grant_o
);

   logic ptr_q, ptr_d;

   always_comb begin
      grant_o = 2'b00;
      ptr_d   = ptr_q;
      case (valid_i)
         2'b01: grant_o = 2'b01;
         2'b10: grant_o = 2'b10;
         2'b11: begin
            grant_o = ptr_q ? 2'b10 : 2'b01;
            ptr_d   = ~ptr_q;
         end
         default: grant_o = 2'b00;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/tpram_arbiter.sv
// Arbitrates two writers and two readers onto a shared two-port RAM, returning read data
// in issue order through an output register backed by a single skid entry.
module tpram_arbiter
   import tpram_arbiter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 1024,
   localparam int unsigned AW        = $clog2(DEPTH)
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic                  w0_valid_i,
   output logic                  w0_ready_o,
   input  logic [AW-1:0]         w0_addr_i,
   input  logic [DATA_WIDTH-1:0] w0_data_i,
   input  logic                  w1_valid_i,
   output logic                  w1_ready_o,
   input  logic [AW-1:0]         w1_addr_i,
   input  logic [DATA_WIDTH-1:0] w1_data_i,
   input  logic                  r0_valid_i,
   output logic                  r0_ready_o,
   input  logic [AW-1:0]         r0_addr_i,
   input  logic                  r1_valid_i,
   output logic                  r1_ready_o,
   input  logic [AW-1:0]         r1_addr_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic                  rsp_id_o,
   output logic [DATA_WIDTH-1:0] rsp_data_o,
   output logic                  ram_cenb_o,
   output logic [AW-1:0]         ram_ab_o,
   output logic [DATA_WIDTH-1:0] ram_db_o,
   output logic                  ram_cena_o,
   output logic [AW-1:0]         ram_aa_o,
   input  logic [DATA_WIDTH-1:0] ram_qa_i
);

   logic [1:0] wvalid, wgrant, rvalid, rgrant;
   logic       issue_ok, drain, land;

   logic                  inflight_q, inflight_d;
   req_id_t               inflight_id_q, inflight_id_d;
   logic                  rsp_valid_q, rsp_valid_d;
   req_id_t               rsp_id_q, rsp_id_d;
   logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic                  skid_valid_q, skid_valid_d;
   req_id_t               skid_id_q, skid_id_d;
   logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;

   assign drain    = rsp_valid_q & rsp_ready_i;
   assign land     = inflight_q;
   assign issue_ok = occupancy(inflight_q, rsp_valid_q, skid_valid_q, drain) <
                     2'(IssueCredits);

   assign wvalid = {w1_valid_i, w0_valid_i} & {2{~reset_i}};
   assign rvalid = {r1_valid_i, r0_valid_i} & {2{~reset_i & issue_ok}};

   rr_arb2 u_wr_arb (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .valid_i (wvalid),
      .grant_o (wgrant)
   );

   rr_arb2 u_rd_arb (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .valid_i (rvalid),
      .grant_o (rgrant)
   );

   always_comb begin
      w0_ready_o = wgrant[0];
      w1_ready_o = wgrant[1];
      r0_ready_o = rgrant[0];
      r1_ready_o = rgrant[1];
      ram_cenb_o = ~|wgrant;
      ram_ab_o   = wgrant[1] ? w1_addr_i : w0_addr_i;
      ram_db_o   = wgrant[1] ? w1_data_i : w0_data_i;
      ram_cena_o = ~|rgrant;
      ram_aa_o   = rgrant[1] ? r1_addr_i : r0_addr_i;
   end

   always_comb begin
      inflight_d    = |rgrant;
      inflight_id_d = rgrant[1];
      rsp_valid_d   = rsp_valid_q;
      rsp_id_d      = rsp_id_q;
      rsp_data_d    = rsp_data_q;
      skid_valid_d  = skid_valid_q;
      skid_id_d     = skid_id_q;
      skid_data_d   = skid_data_q;
      if (!rsp_valid_q || rsp_ready_i) begin
         // The skid entry is older than anything landing now, so it goes out first.
         if (skid_valid_q) begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = skid_id_q;
            rsp_data_d   = skid_data_q;
            skid_valid_d = land;
            if (land) begin
               skid_id_d   = inflight_id_q;
               skid_data_d = ram_qa_i;
            end
         end else if (land) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = inflight_id_q;
            rsp_data_d  = ram_qa_i;
         end else begin
            rsp_valid_d = 1'b0;
         end
      end else if (land) begin
         skid_valid_d = 1'b1;
         skid_id_d    = inflight_id_q;
         skid_data_d  = ram_qa_i;
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         inflight_q    <= 1'b0;
         inflight_id_q <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_id_q      <= 1'b0;
         rsp_data_q    <= '0;
         skid_valid_q  <= 1'b0;
         skid_id_q     <= 1'b0;
         skid_data_q   <= '0;
      end else begin
         inflight_q    <= inflight_d;
         inflight_id_q <= inflight_id_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_id_q      <= rsp_id_d;
         rsp_data_q    <= rsp_data_d;
         skid_valid_q  <= skid_valid_d;
         skid_id_q     <= skid_id_d;
         skid_data_q   <= skid_data_d;
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_id_o    = rsp_id_q;
   assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_tpram_arbiter.sv
// Directed and random bench for tpram_arbiter with a behavioural two-port RAM alongside.
module tb_tpram_arbiter;

   localparam int DW    = 32;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          w0_valid, w0_ready, w1_valid, w1_ready;
   logic [AW-1:0] w0_addr, w1_addr;
   logic [DW-1:0] w0_data, w1_data;
   logic          r0_valid, r0_ready, r1_valid, r1_ready;
   logic [AW-1:0] r0_addr, r1_addr;
   logic          rsp_valid, rsp_ready, rsp_id;
   logic [DW-1:0] rsp_data;
   logic          ram_cenb, ram_cena;
   logic [AW-1:0] ram_ab, ram_aa;
   logic [DW-1:0] ram_db;
   logic [DW-1:0] ram_qa = '0;
   logic [DW-1:0] mem [DEPTH] = '{default: '0};

   int errors = 0;
   int checks = 0;
   logic [DW:0] exp_q[$];

   localparam logic [DW-1:0] DataA = 32'hA5A5_0001;
   localparam logic [DW-1:0] DataB = 32'h5A5A_0002;

   always #5 clk = ~clk;

   // Read port returns old contents on a same-address write; idle cycles yield garbage.
   always @(posedge clk) begin
      if (!ram_cena) ram_qa <= mem[ram_aa];
      else ram_qa <= $urandom;
      if (!ram_cenb) mem[ram_ab] <= ram_db;
   end

   tpram_arbiter #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH)
   ) dut (
      .clock_i     (clk),
      .reset_i     (rst),
      .w0_valid_i  (w0_valid),
      .w0_ready_o  (w0_ready),
      .w0_addr_i   (w0_addr),
      .w0_data_i   (w0_data),
      .w1_valid_i  (w1_valid),
      .w1_ready_o  (w1_ready),
      .w1_addr_i   (w1_addr),
      .w1_data_i   (w1_data),
      .r0_valid_i  (r0_valid),
      .r0_ready_o  (r0_ready),
      .r0_addr_i   (r0_addr),
      .r1_valid_i  (r1_valid),
      .r1_ready_o  (r1_ready),
      .r1_addr_i   (r1_addr),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_id_o    (rsp_id),
      .rsp_data_o  (rsp_data),
      .ram_cenb_o  (ram_cenb),
      .ram_ab_o    (ram_ab),
      .ram_db_o    (ram_db),
      .ram_cena_o  (ram_cena),
      .ram_aa_o    (ram_aa),
      .ram_qa_i    (ram_qa)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      w0_valid = 0; w1_valid = 0; r0_valid = 0; r1_valid = 0;
   endtask

   task automatic all_valid();
      w0_valid = 1; w1_valid = 1; r0_valid = 1; r1_valid = 1;
   endtask

   task automatic check_quiet(input string tag);
      check_eq({tag, "_w0rdy"}, w0_ready, 0);
      check_eq({tag, "_w1rdy"}, w1_ready, 0);
      check_eq({tag, "_r0rdy"}, r0_ready, 0);
      check_eq({tag, "_r1rdy"}, r1_ready, 0);
      check_eq({tag, "_cena"}, ram_cena, 1);
      check_eq({tag, "_cenb"}, ram_cenb, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1; rsp_ready = 0;
      w0_addr = 5; w1_addr = 6; w0_data = DataA; w1_data = DataB;
      r0_addr = 5; r1_addr = 6;
      all_valid();
      @(negedge clk);
      @(negedge clk);
      #1;
      check_quiet("reset");
      check_eq("reset_rsp_valid", rsp_valid, 0);
      check_eq("reset_rsp_id", rsp_id, 0);
      check_eq("reset_rsp_data", rsp_data, 0);
      idle_inputs();
      rst = 0;
      @(negedge clk);

      // Both writers compete for three cycles.
      w0_valid = 1; w1_valid = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check_eq("rr_w0rdy", w0_ready, (i != 1));
         check_eq("rr_w1rdy", w1_ready, (i == 1));
         check_eq("rr_cenb", ram_cenb, 0);
         check_eq("rr_ab", ram_ab, (i == 1) ? 6 : 5);
         check_eq("rr_db", ram_db, (i == 1) ? DataB : DataA);
         @(negedge clk);
      end
      idle_inputs();

      // Write then read back through r1, checking two-cycle latency.
      w0_valid = 1; w0_addr = 10; w0_data = 32'hDEAD_BEEF;
      #1;
      check_eq("wr10_rdy", w0_ready, 1);
      @(negedge clk);
      w0_valid = 0; r1_valid = 1; r1_addr = 10; rsp_ready = 1;
      #1;
      check_eq("rd10_r1rdy", r1_ready, 1);
      check_eq("rd10_cena", ram_cena, 0);
      check_eq("rd10_aa", ram_aa, 10);
      @(negedge clk);
      r1_valid = 0;
      #1;
      check_eq("rd10_n1_valid", rsp_valid, 0);
      check_eq("rd10_n1_cena", ram_cena, 1);
      @(negedge clk);
      #1;
      check_eq("rd10_n2_valid", rsp_valid, 1);
      check_eq("rd10_id", rsp_id, 1);
      check_eq("rd10_data", rsp_data, 32'hDEAD_BEEF);
      @(negedge clk);
      #1;
      check_eq("rd10_n3_valid", rsp_valid, 0);

      // Backpressure: only two reads may be outstanding.
      rsp_ready = 0; r0_valid = 1; r0_addr = 5; r1_valid = 1; r1_addr = 6;
      #1;
      check_eq("bp_a_r0rdy", r0_ready, 1);
      check_eq("bp_a_r1rdy", r1_ready, 0);
      @(negedge clk);
      #1;
      check_eq("bp_b_r0rdy", r0_ready, 0);
      check_eq("bp_b_r1rdy", r1_ready, 1);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         #1;
         check_eq("bp_hold_r0rdy", r0_ready, 0);
         check_eq("bp_hold_r1rdy", r1_ready, 0);
         check_eq("bp_hold_cena", ram_cena, 1);
         check_eq("bp_hold_valid", rsp_valid, 1);
         check_eq("bp_hold_id", rsp_id, 0);
         check_eq("bp_hold_data", rsp_data, DataA);
         @(negedge clk);
      end
      r0_valid = 0; r1_valid = 0; rsp_ready = 1;
      #1;
      check_eq("bp_out0_valid", rsp_valid, 1);
      check_eq("bp_out0_id", rsp_id, 0);
      check_eq("bp_out0_data", rsp_data, DataA);
      @(negedge clk);
      #1;
      check_eq("bp_out1_valid", rsp_valid, 1);
      check_eq("bp_out1_id", rsp_id, 1);
      check_eq("bp_out1_data", rsp_data, DataB);
      @(negedge clk);
      #1;
      check_eq("bp_empty", rsp_valid, 0);

      // Same-cycle write and read of one address returns the old word.
      w0_valid = 1; w0_addr = 3; w0_data = 32'h2222;
      @(negedge clk);
      w0_data = 32'h1111; r0_valid = 1; r0_addr = 3;
      #1;
      check_eq("wr_rd_w0rdy", w0_ready, 1);
      check_eq("wr_rd_r0rdy", r0_ready, 1);
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      #1;
      check_eq("old_valid", rsp_valid, 1);
      check_eq("old_data", rsp_data, 32'h2222);
      r0_valid = 1;
      @(negedge clk);
      r0_valid = 0;
      @(negedge clk);
      #1;
      check_eq("new_valid", rsp_valid, 1);
      check_eq("new_data", rsp_data, 32'h1111);
      @(negedge clk);

      // Reset right after a read issue; read pointer is moved to 1 first.
      w0_addr = 5; w1_addr = 6; w0_data = DataA; w1_data = DataB;
      r0_addr = 5; r1_addr = 6; r0_valid = 1; r1_valid = 1;
      #1;
      check_eq("pre_rst_r0rdy", r0_ready, 1);
      @(negedge clk);
      rst = 1;
      all_valid();
      #1;
      check_quiet("mid_rst");
      @(negedge clk);
      rst = 0;
      idle_inputs();
      for (int i = 0; i < 4; i++) begin
         #1;
         check_eq("post_rst_valid", rsp_valid, 0);
         check_eq("post_rst_cena", ram_cena, 1);
         check_eq("post_rst_cenb", ram_cenb, 1);
         @(negedge clk);
      end
      all_valid();
      #1;
      check_eq("ptr_w0rdy", w0_ready, 1);
      check_eq("ptr_w1rdy", w1_ready, 0);
      check_eq("ptr_r0rdy", r0_ready, 1);
      check_eq("ptr_r1rdy", r1_ready, 0);
      @(negedge clk);
      idle_inputs();
      for (int i = 0; i < 4; i++) @(negedge clk);

      // Random traffic against a response scoreboard.
      for (int n = 0; n < 400; n++) begin
         w0_valid = 1'($urandom_range(0, 1)); w0_addr = AW'($urandom_range(0, DEPTH - 1));
         w1_valid = 1'($urandom_range(0, 1)); w1_addr = AW'($urandom_range(0, DEPTH - 1));
         w0_data = $urandom; w1_data = $urandom;
         r0_valid = 1'($urandom_range(0, 1)); r0_addr = AW'($urandom_range(0, DEPTH - 1));
         r1_valid = 1'($urandom_range(0, 1)); r1_addr = AW'($urandom_range(0, DEPTH - 1));
         rsp_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) check_eq("rand_spurious", 1, 0);
            else check_eq("rand_rsp", {rsp_id, rsp_data}, exp_q.pop_front());
         end
         if (r0_valid && r0_ready) exp_q.push_back({1'b0, mem[r0_addr]});
         if (r1_valid && r1_ready) exp_q.push_back({1'b1, mem[r1_addr]});
         @(negedge clk);
      end
      idle_inputs();
      rsp_ready = 1;
      for (int n = 0; n < 20 && exp_q.size() != 0; n++) begin
         #1;
         if (rsp_valid) check_eq("drain_rsp", {rsp_id, rsp_data}, exp_q.pop_front());
         @(negedge clk);
      end
      check_eq("drain_left", exp_q.size(), 0);
      #1;
      check_eq("drain_idle", rsp_valid, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
